cmd_responder: RTL and testbench

CMD_RESPONDER -- requirements
Module: cmd_responder

---
 rtl/sd_pkg.sv | 10 +
 rtl/crc7.sv | 24 ++
 rtl/cmd_responder.sv | 173 +++++++++++++++++
 tb/tb_cmd_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command-line responder.
package sd_pkg;

    typedef enum logic [2:0] {IDLE, RECV, WAIT_RESP, GAP, SEND} state_t;

    localparam int         CMD_FRAME_LEN = 48;
    localparam logic [6:0] CRC7_POLY     = 7'h09;
    localparam int         NCR_DEFAULT   = 2;

endpackage

// File: rtl/crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled clock, MSB-first.
module crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic fb;

    assign fb = din ^ crc[6];

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            crc <= '0;
        else if (en)
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end

endmodule

// File: rtl/cmd_responder.sv
// SD CMD-line responder: receives host command frames, drives card responses.
// Define CMD_CRC_CHECK_EN to check the received CRC7 as well as the end bit.
module cmd_responder
    import sd_pkg::*;
#(
    parameter int NCR = NCR_DEFAULT
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        icmd_sd,
    output logic        ocmd_sd,
    output logic        ocmd_oe,
    output logic [5:0]  ocmd_index,
    output logic [31:0] ocmd_arg,
    output logic        ocmd_valid,
    output logic        ocrc_fail,
    input  logic        iresp_start,
    input  logic [5:0]  iresp_index,
    input  logic [31:0] iresp_arg,
    input  logic        iresp_nocrc,
    output logic        oresp_done
);

    state_t      state, state_nxt;
    logic [5:0]  bit_cnt;
    logic        start_seen;
    logic [44:0] rx_sr;
    logic [45:0] rx_tail;
    logic        rx_fail;
    logic [39:0] tx_sr;
    logic        tx_nocrc;
    logic [6:0]  tx_crc;
    logic        tx_crc_clr, tx_crc_en;
    logic        frame_last, gap_last, host_start, listening;

    // rx_tail is the frame after its two leading bits, including the bit on the line now
    assign rx_tail    = {rx_sr, icmd_sd};
    assign frame_last = (bit_cnt == 6'(CMD_FRAME_LEN - 1));
    assign gap_last   = (bit_cnt == 6'(NCR - 1));
    assign listening  = (state == IDLE) || (state == WAIT_RESP);
    assign host_start = start_seen & icmd_sd;

`ifdef CMD_CRC_CHECK_EN
    logic [6:0] rx_crc;
    logic       rx_crc_clr, rx_crc_en;

    // The leading 0 leaves a cleared CRC unchanged, so only the direction bit is fed while listening
    assign rx_crc_clr = listening && !start_seen;
    assign rx_crc_en  = (listening && host_start) || (state == RECV && bit_cnt < 6'd40);
    assign rx_fail    = (rx_tail[7:1] != rx_crc) || !rx_tail[0];

    crc7 u_rx_crc (
        .clk  (iclk),
        .rst_n(irst),
        .clr  (rx_crc_clr),
        .en   (rx_crc_en),
        .din  (icmd_sd),
        .crc  (rx_crc)
    );
`else
    assign rx_fail = !rx_tail[0];
`endif

    crc7 u_tx_crc (
        .clk  (iclk),
        .rst_n(irst),
        .clr  (tx_crc_clr),
        .en   (tx_crc_en),
        .din  (tx_sr[39]),
        .crc  (tx_crc)
    );

    always_ff @(posedge iclk) begin
        if (!irst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ocmd_sd    = 1'b1;
        ocmd_oe    = 1'b0;
        tx_crc_clr = 1'b0;
        tx_crc_en  = 1'b0;
        case (state)
            IDLE: begin
                if (host_start)
                    state_nxt = RECV;
            end
            RECV: begin
                if (frame_last)
                    state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (iresp_start)
                    state_nxt = GAP;
                else if (host_start)
                    state_nxt = RECV;
            end
            GAP: begin
                ocmd_oe    = 1'b1;
                tx_crc_clr = 1'b1;
                if (gap_last)
                    state_nxt = SEND;
            end
            SEND: begin
                ocmd_oe   = 1'b1;
                tx_crc_en = (bit_cnt < 6'd40);
                if (bit_cnt < 6'd40)
                    ocmd_sd = tx_sr[39];
                else if (bit_cnt < 6'd47)
                    ocmd_sd = tx_nocrc | tx_crc[3'(6'd46 - bit_cnt)];
                if (frame_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!irst) begin
            bit_cnt    <= '0;
            start_seen <= 1'b0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            tx_nocrc   <= 1'b0;
            ocmd_index <= '0;
            ocmd_arg   <= '0;
            ocmd_valid <= 1'b0;
            ocrc_fail  <= 1'b0;
            oresp_done <= 1'b0;
        end else begin
            ocmd_valid <= 1'b0;
            oresp_done <= 1'b0;
            case (state)
                IDLE, WAIT_RESP: begin
                    // A second low bit is a card-direction frame: drop it and look again
                    start_seen <= !start_seen && !icmd_sd;
                    bit_cnt    <= 6'd2;
                    if (state == WAIT_RESP && iresp_start) begin
                        start_seen <= 1'b0;
                        bit_cnt    <= '0;
                        tx_sr      <= {2'b00, iresp_index, iresp_arg};
                        tx_nocrc   <= iresp_nocrc;
                    end
                end
                RECV: begin
                    rx_sr   <= rx_tail[44:0];
                    bit_cnt <= bit_cnt + 6'd1;
                    if (frame_last) begin
                        ocmd_index <= rx_tail[45:40];
                        ocmd_arg   <= rx_tail[39:8];
                        ocrc_fail  <= rx_fail;
                        ocmd_valid <= 1'b1;
                        bit_cnt    <= '0;
                    end
                end
                GAP: bit_cnt <= gap_last ? 6'd0 : bit_cnt + 6'd1;
                SEND: begin
                    tx_sr   <= {tx_sr[38:0], 1'b0};
                    bit_cnt <= bit_cnt + 6'd1;
                    if (frame_last) begin
                        oresp_done <= 1'b1;
                        bit_cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_responder.sv
// Bench for cmd_responder: directed frames plus random command/response traffic, two NCR settings.
module tb_cmd_responder;

    logic        iclk = 1'b0, irst = 1'b0, icmd_sd = 1'b1;
    logic        iresp_start = 1'b0, iresp_nocrc = 1'b0;
    logic [5:0]  iresp_index = '0;
    logic [31:0] iresp_arg = '0;

    logic        ocmd_sd, ocmd_oe, ocmd_valid, ocrc_fail, oresp_done;
    logic [5:0]  ocmd_index;
    logic [31:0] ocmd_arg;
    logic        ocmd_sd_8, ocmd_oe_8, ocmd_valid_8, ocrc_fail_8, oresp_done_8;
    logic [5:0]  ocmd_index_8;
    logic [31:0] ocmd_arg_8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 iclk = ~iclk;

    cmd_responder u_dut (
        .iclk(iclk), .irst(irst), .icmd_sd(icmd_sd),
        .ocmd_sd(ocmd_sd), .ocmd_oe(ocmd_oe),
        .ocmd_index(ocmd_index), .ocmd_arg(ocmd_arg),
        .ocmd_valid(ocmd_valid), .ocrc_fail(ocrc_fail),
        .iresp_start(iresp_start), .iresp_index(iresp_index),
        .iresp_arg(iresp_arg), .iresp_nocrc(iresp_nocrc),
        .oresp_done(oresp_done)
    );

    cmd_responder #(.NCR(8)) u_dut8 (
        .iclk(iclk), .irst(irst), .icmd_sd(icmd_sd),
        .ocmd_sd(ocmd_sd_8), .ocmd_oe(ocmd_oe_8),
        .ocmd_index(ocmd_index_8), .ocmd_arg(ocmd_arg_8),
        .ocmd_valid(ocmd_valid_8), .ocrc_fail(ocrc_fail_8),
        .iresp_start(iresp_start), .iresp_index(iresp_index),
        .iresp_arg(iresp_arg), .iresp_nocrc(iresp_nocrc),
        .oresp_done(oresp_done_8)
    );

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7_div(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] host_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, crc7_div({2'b01, idx, arg}), 1'b1};
    endfunction

    function automatic logic [47:0] resp_frame(input logic [5:0] idx, input logic [31:0] arg, input logic nocrc);
        return {2'b00, idx, arg, nocrc ? 7'h7F : crc7_div({2'b00, idx, arg}), 1'b1};
    endfunction

    function automatic logic exp_fail(input logic [47:0] f);
`ifdef CMD_CRC_CHECK_EN
        return (f[7:1] != crc7_div(f[47:8])) || !f[0];
`else
        return !f[0];
`endif
    endfunction

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            icmd_sd = f[i];
            step();
            if (i > 0) begin
                chk("rx_oe", ocmd_oe, 0);
                chk("rx_oe8", ocmd_oe_8, 0);
                chk("rx_valid_early", ocmd_valid, 0);
            end
        end
        icmd_sd = 1'b1;
        chk("rx_valid", ocmd_valid, 1);
        chk("rx_valid8", ocmd_valid_8, 1);
        chk("rx_index", ocmd_index, f[45:40]);
        chk("rx_arg", ocmd_arg, f[39:8]);
        chk("rx_arg8", ocmd_arg_8, f[39:8]);
        chk("rx_crc_fail", ocrc_fail, exp_fail(f));
        chk("rx_crc_fail8", ocrc_fail_8, exp_fail(f));
        step();
        chk("rx_valid_pulse", ocmd_valid, 0);
        chk("rx_valid_pulse8", ocmd_valid_8, 0);
    endtask

    // Expected line for cycle k after the iresp_start cycle: n idle-high cycles, 48 bits, then done
    task automatic exp_line(input string tag, input int k, input int n, input logic [47:0] rf,
                            input logic sd, input logic oe, input logic done);
        logic esd, eoe, edone;
        esd = 1'b1; eoe = 1'b0; edone = 1'b0;
        if (k <= n)
            eoe = 1'b1;
        else if (k <= n + 48) begin
            eoe = 1'b1;
            esd = rf[47 - (k - n - 1)];
        end else if (k == n + 49)
            edone = 1'b1;
        chk({tag, "_sd"}, sd, esd);
        chk({tag, "_oe"}, oe, eoe);
        chk({tag, "_done"}, done, edone);
    endtask

    task automatic respond(input logic [5:0] idx, input logic [31:0] arg, input logic nocrc,
                           input logic [47:0] rf, input logic collide, input int abort_k);
        iresp_index = idx; iresp_arg = arg; iresp_nocrc = nocrc;
        iresp_start = 1'b1;
        icmd_sd     = !collide;
        step();
        iresp_start = 1'b0;
        iresp_index = 6'($urandom);
        iresp_arg   = $urandom;
        iresp_nocrc = 1'($urandom);
        for (int k = 1; k <= 58; k++) begin
            exp_line("resp2", k, 2, rf, ocmd_sd, ocmd_oe, oresp_done);
            exp_line("resp8", k, 8, rf, ocmd_sd_8, ocmd_oe_8, oresp_done_8);
            if (k == abort_k) begin
                irst = 1'b0;
                step();
                chk("abort_oe", ocmd_oe, 0);
                chk("abort_oe8", ocmd_oe_8, 0);
                chk("abort_sd", ocmd_sd, 1);
                chk("abort_done", oresp_done, 0);
                irst    = 1'b1;
                icmd_sd = 1'b1;
                return;
            end
            if (collide && k == 1)
                icmd_sd = 1'b1;
            else
                icmd_sd = (k <= 49) ? 1'($urandom) : 1'b1;
            step();
        end
        icmd_sd = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [47:0] f;
        logic [5:0]  idx, ridx;
        logic [31:0] arg, rarg;
        logic        rnc;
        int          j;

        repeat (3) step();
        chk("rst_sd", ocmd_sd, 1);
        chk("rst_oe", ocmd_oe, 0);
        chk("rst_valid", ocmd_valid, 0);
        chk("rst_fail", ocrc_fail, 0);
        chk("rst_done", oresp_done, 0);
        chk("rst_index", ocmd_index, 0);
        chk("rst_arg", ocmd_arg, 0);
        chk("rst_oe8", ocmd_oe_8, 0);
        irst = 1'b1;
        step();

        // response request while idle must be ignored
        iresp_start = 1'b1; iresp_index = 6'h15; iresp_arg = 32'h1234;
        step();
        iresp_start = 1'b0;
        repeat (12) begin
            chk("idle_resp_oe", ocmd_oe, 0);
            chk("idle_resp_oe8", ocmd_oe_8, 0);
            step();
        end

        // card-direction start (0,0) is not a host frame
        icmd_sd = 1'b0; step(); step();
        icmd_sd = 1'b1;
        repeat (4) begin
            chk("nonhost_valid", ocmd_valid, 0);
            step();
        end

        send_frame(48'h40_0000_0000_95);
        repeat (3) step();
        send_frame(48'h40_0000_0000_95);
        send_frame(48'h48_0000_01AA_87);
        respond(6'h3F, 32'h80FF8000, 1'b1, 48'h3F_80FF_8000_FF, 1'b0, 0);
        send_frame(48'h40_0000_0000_97);
        send_frame(48'h40_0000_0000_94);
        respond(6'h08, 32'h000001AA, 1'b0, resp_frame(6'h08, 32'h000001AA, 1'b0), 1'b1, 0);

        for (int t = 0; t < 8; t++) begin
            idx = 6'($urandom);
            arg = $urandom;
            f   = host_frame(idx, arg);
            if ($urandom_range(0, 2) == 0) begin
                j = $urandom_range(0, 7);
                f[j] = ~f[j];
            end
            send_frame(f);
            ridx = 6'($urandom);
            rarg = $urandom;
            rnc  = 1'($urandom);
            respond(ridx, rarg, rnc, resp_frame(ridx, rarg, rnc), 1'($urandom), 0);
        end

        // reset during SEND bit 20 of the NCR=2 instance
        send_frame(48'h48_0000_01AA_87);
        respond(6'h11, 32'hDEADBEEF, 1'b0, resp_frame(6'h11, 32'hDEADBEEF, 1'b0), 1'b0, 23);
        repeat (60) begin
            chk("post_abort_done", oresp_done, 0);
            chk("post_abort_done8", oresp_done_8, 0);
            chk("post_abort_oe", ocmd_oe, 0);
            step();
        end
        send_frame(48'h40_0000_0000_95);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
